// File: rtl/loader_pkg.sv
// Shared types and constants for the byte-to-word RAM loader.
// Bytes are packed little-endian into WORD_BYTES-byte words.
package loader_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        WRITE   = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int BYTE_W     = 8;
    localparam int WORD_W     = WORD_BYTES * BYTE_W;

endpackage

// File: rtl/ram_loader_if.sv
// RAM write port: address, data and a we/ready handshake.
// The loader is the master; the RAM answers with mem_ready.
interface ram_loader_if #(
    parameter int ADDR_WIDTH = 8
) ();
    import loader_pkg::*;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WORD_W-1:0]     mem_wdata;
    logic                  mem_we;
    logic                  mem_ready;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        input  mem_ready
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        output mem_ready
    );
endinterface

// File: rtl/ram_loader_sync_edge.sv
// Two-flop synchronizer for an async strobe and its byte, with rising-edge detect.
// byte_edge and byte_data are aligned: the data was sampled with the first high strobe.
module sync_edge
    import loader_pkg::*;
(
    input  logic              w_clk_low,
    input  logic              rst,
    input  logic              strobe_in,
    input  logic [BYTE_W-1:0] data_in,
    output logic              byte_edge,
    output logic [BYTE_W-1:0] byte_data
);

    logic              strobe_s1_reg;
    logic              strobe_s2_reg;
    logic              strobe_s3_reg;
    logic [BYTE_W-1:0] data_s1_reg;
    logic [BYTE_W-1:0] data_s2_reg;

    always_ff @(posedge w_clk_low) begin
        if (rst) begin
            strobe_s1_reg <= 1'b0;
            strobe_s2_reg <= 1'b0;
            strobe_s3_reg <= 1'b0;
            data_s1_reg   <= '0;
            data_s2_reg   <= '0;
        end else begin
            strobe_s1_reg <= strobe_in;
            strobe_s2_reg <= strobe_s1_reg;
            strobe_s3_reg <= strobe_s2_reg;
            data_s1_reg   <= data_in;
            data_s2_reg   <= data_s1_reg;
        end
    end

    assign byte_edge = strobe_s2_reg & ~strobe_s3_reg;
    assign byte_data = data_s2_reg;

endmodule

// File: rtl/ram_loader.sv
// Collects strobed bytes into 32-bit words and writes them to sequential RAM
// addresses from 0 until DEPTH words are stored; a one-byte hold covers writes.
module ram_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  w_clk_low,
    input  logic                  rst,
    input  logic [BYTE_W-1:0]     port_in,
    input  logic                  port_strobe,
    ram_loader_if.master          mem,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  done,
    output logic                  overflow
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = {ADDR_WIDTH{1'b1}};
    localparam logic [1:0]            LAST_IDX  = 2'(WORD_BYTES - 1);
    localparam int                    ASM_W     = (WORD_BYTES - 1) * BYTE_W;

    logic              byte_edge;
    logic [BYTE_W-1:0] byte_data;

    sync_edge u_sync_edge (
        .w_clk_low (w_clk_low),
        .rst       (rst),
        .strobe_in (port_strobe),
        .data_in   (port_in),
        .byte_edge (byte_edge),
        .byte_data (byte_data)
    );

    state_t                state_reg;
    logic [1:0]            byte_idx_reg;
    logic [ASM_W-1:0]      asm_reg;
    logic [ASM_W-1:0]      asm_next;
    logic [BYTE_W-1:0]     hold_reg;
    logic                  hold_valid_reg;
    logic [ADDR_WIDTH-1:0] mem_addr_reg;
    logic [WORD_W-1:0]     mem_wdata_reg;
    logic                  mem_we_reg;
    logic [ADDR_WIDTH:0]   word_count_reg;
    logic                  done_reg;
    logic                  overflow_reg;

    // Lower three byte lanes of the word under assembly; byte 3 goes straight to mem_wdata.
    for (genvar gi = 0; gi < WORD_BYTES - 1; gi++) begin : g_lane
        assign asm_next[gi*BYTE_W +: BYTE_W] = (byte_idx_reg == 2'(gi)) ? byte_data
                                             : asm_reg[gi*BYTE_W +: BYTE_W];
    end

    always_ff @(posedge w_clk_low) begin
        if (rst) begin
            state_reg      <= COLLECT;
            byte_idx_reg   <= 2'd0;
            asm_reg        <= '0;
            hold_reg       <= '0;
            hold_valid_reg <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            mem_we_reg     <= 1'b0;
            word_count_reg <= '0;
            done_reg       <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            case (state_reg)
                COLLECT: begin
                    if (byte_edge) begin
                        if (byte_idx_reg == LAST_IDX) begin
                            mem_wdata_reg <= {byte_data, asm_reg};
                            mem_we_reg    <= 1'b1;
                            byte_idx_reg  <= 2'd0;
                            state_reg     <= WRITE;
                        end else begin
                            asm_reg      <= asm_next;
                            byte_idx_reg <= byte_idx_reg + 2'd1;
                        end
                    end
                end

                WRITE: begin
                    if (mem.mem_ready) begin
                        mem_we_reg     <= 1'b0;
                        mem_addr_reg   <= (mem_addr_reg == ADDR_MAX) ? mem_addr_reg
                                                                     : mem_addr_reg + ADDR_ONE;
                        word_count_reg <= word_count_reg + CNT_ONE;
                        hold_valid_reg <= 1'b0;
                        if (word_count_reg + CNT_ONE == DEPTH_W) begin
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            state_reg <= COLLECT;
                            // A held byte opens the next word; a simultaneous edge would be a second one.
                            if (hold_valid_reg) begin
                                asm_reg[BYTE_W-1:0] <= hold_reg;
                                byte_idx_reg        <= 2'd1;
                                if (byte_edge) begin
                                    overflow_reg <= 1'b1;
                                end
                            end else if (byte_edge) begin
                                asm_reg[BYTE_W-1:0] <= byte_data;
                                byte_idx_reg        <= 2'd1;
                            end
                        end
                    end else if (byte_edge) begin
                        if (hold_valid_reg) begin
                            overflow_reg <= 1'b1;
                        end else begin
                            hold_reg       <= byte_data;
                            hold_valid_reg <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    mem_we_reg <= 1'b0;
                end

                default: begin
                    state_reg  <= COLLECT;
                    mem_we_reg <= 1'b0;
                end
            endcase
        end
    end

    assign mem.mem_addr  = mem_addr_reg;
    assign mem.mem_wdata = mem_wdata_reg;
    assign mem.mem_we    = mem_we_reg;
    assign word_count    = word_count_reg;
    assign done          = done_reg;
    assign overflow      = overflow_reg;

endmodule

// File: tb/tb_ram_loader.sv
// Directed scenarios with random byte values; expected RAM writes come from a
// byte-queue model that packs every accepted byte little-endian, 4 per word.
module tb_ram_loader;

    localparam int AW    = 8;
    localparam int DEPTH = 4;

    logic          w_clk_low = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    port_in = 8'h00;
    logic          port_strobe = 1'b0;
    logic [AW:0]   word_count;
    logic          done;
    logic          overflow;

    ram_loader_if #(.ADDR_WIDTH(AW)) bus ();

    ram_loader #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .w_clk_low   (w_clk_low),
        .rst         (rst),
        .port_in     (port_in),
        .port_strobe (port_strobe),
        .mem         (bus),
        .word_count  (word_count),
        .done        (done),
        .overflow    (overflow)
    );

    always #5 w_clk_low = ~w_clk_low;

    int n_cmp = 0;
    int n_err = 0;

    // RAM-side responder
    bit ready_tie   = 1'b0;
    bit ready_block = 1'b0;
    int ready_delay = 0;
    int we_age      = 0;

    initial begin
        bus.mem_ready = 1'b0;
        forever begin
            @(posedge w_clk_low);
            #1;
            if (ready_tie) begin
                bus.mem_ready = 1'b1;
            end else if (bus.mem_we && !ready_block) begin
                bus.mem_ready = (we_age >= ready_delay);
                we_age++;
            end else begin
                bus.mem_ready = 1'b0;
                we_age = 0;
            end
        end
    end

    // Write monitor: logs accepted writes and counts mem_we cycles / instability
    logic [AW-1:0] wr_addr_q[$];
    logic [31:0]   wr_data_q[$];
    int            we_cycles = 0;
    int            stab_err  = 0;
    logic          prev_we   = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [31:0]   prev_data = '0;

    initial begin
        forever begin
            @(negedge w_clk_low);
            if (bus.mem_we === 1'b1) begin
                we_cycles++;
                if (prev_we && (bus.mem_addr !== prev_addr || bus.mem_wdata !== prev_data))
                    stab_err++;
                if (bus.mem_ready === 1'b1) begin
                    wr_addr_q.push_back(bus.mem_addr);
                    wr_data_q.push_back(bus.mem_wdata);
                end
            end
            prev_we   = bus.mem_we;
            prev_addr = bus.mem_addr;
            prev_data = bus.mem_wdata;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, required $finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

    // Reference model: bytes the loader should have accepted, in order
    logic [7:0] exp_bytes[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge w_clk_low);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit accepted);
        port_in = b;
        tick(1);
        port_strobe = 1'b1;
        tick(3);
        port_strobe = 1'b0;
        tick(3);
        if (accepted) exp_bytes.push_back(b);
    endtask

    task automatic send_random(input int n, input bit accepted);
        for (int i = 0; i < n; i++) send_byte(8'($urandom_range(0, 255)), accepted);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    task automatic clear_logs();
        exp_bytes.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        we_cycles = 0;
        stab_err  = 0;
    endtask

    task automatic check_idle(input string tag);
        @(negedge w_clk_low);
        check({tag, ".mem_we"},     64'(bus.mem_we),    64'd0);
        check({tag, ".mem_addr"},   64'(bus.mem_addr),  64'd0);
        check({tag, ".mem_wdata"},  64'(bus.mem_wdata), 64'd0);
        check({tag, ".word_count"}, 64'(word_count),    64'd0);
        check({tag, ".done"},       64'(done),          64'd0);
        check({tag, ".overflow"},   64'(overflow),      64'd0);
    endtask

    task automatic verify_writes(input string tag);
        int nw;
        logic [31:0] w;
        nw = exp_bytes.size() / 4;
        if (nw > DEPTH) nw = DEPTH;
        check({tag, ".nwrites"}, 64'(wr_addr_q.size()), 64'(nw));
        for (int i = 0; i < nw && i < wr_addr_q.size(); i++) begin
            w = 32'd0;
            for (int k = 0; k < 4; k++) w = w | (32'(exp_bytes[4*i + k]) << (8 * k));
            check($sformatf("%s.addr%0d", tag, i),  64'(wr_addr_q[i]), 64'(i));
            check($sformatf("%s.wdata%0d", tag, i), 64'(wr_data_q[i]), 64'(w));
        end
    endtask

    initial begin
        logic [7:0] b;
        int         we_snap;

        // Power-up reset
        tick(2);
        do_reset();
        check_idle("reset");

        // 1: single word, ready tied high
        clear_logs();
        ready_tie = 1'b1;
        send_byte(8'h13, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        tick(3);
        verify_writes("t1");
        check("t1.we_cycles",  64'(we_cycles),  64'd1);
        check("t1.word_count", 64'(word_count), 64'd1);
        check("t1.mem_addr",   64'(bus.mem_addr), 64'd1);

        // 2: two words with a 5-cycle ready delay
        do_reset();
        clear_logs();
        ready_tie   = 1'b0;
        ready_delay = 5;
        for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b1);
        tick(10);
        verify_writes("t2");
        check("t2.stable",     64'(stab_err),   64'd0);
        check("t2.we_cycles",  64'(we_cycles),  64'd12);
        check("t2.word_count", 64'(word_count), 64'd2);

        // 3: fill all DEPTH words, then extra bytes are ignored
        do_reset();
        clear_logs();
        ready_tie = 1'b1;
        send_random(4 * DEPTH, 1'b1);
        tick(3);
        verify_writes("t3");
        check("t3.done", 64'(done), 64'd1);
        we_snap = we_cycles;
        send_random(4, 1'b0);
        tick(3);
        check("t3.no_more_we", 64'(we_cycles),    64'(we_snap));
        check("t3.overflow",   64'(overflow),     64'd0);
        check("t3.mem_addr",   64'(bus.mem_addr), 64'(DEPTH));
        check("t3.word_count", 64'(word_count),   64'(DEPTH));
        check("t3.done_stays", 64'(done),         64'd1);

        // 4: ready stalled; one byte held, the next one lost
        do_reset();
        clear_logs();
        ready_tie   = 1'b0;
        ready_delay = 0;
        ready_block = 1'b1;
        send_random(4, 1'b1);
        send_random(1, 1'b1);
        check("t4.no_overflow_yet", 64'(overflow), 64'd0);
        send_random(1, 1'b0);
        check("t4.overflow", 64'(overflow),   64'd1);
        check("t4.we_held",  64'(bus.mem_we), 64'd1);
        ready_block = 1'b0;
        tick(3);
        send_random(3, 1'b1);
        tick(4);
        verify_writes("t4");
        check("t4.word_count", 64'(word_count), 64'd2);

        // 5: reset mid-word and mid-write, then a clean word at address 0
        do_reset();
        clear_logs();
        ready_tie = 1'b1;
        send_random(2, 1'b0);
        do_reset();
        check_idle("t5.rst_collect");
        ready_tie   = 1'b0;
        ready_block = 1'b1;
        send_random(4, 1'b0);
        check("t5.in_write", 64'(bus.mem_we), 64'd1);
        tick(1);
        do_reset();
        check_idle("t5.rst_write");
        ready_block = 1'b0;
        clear_logs();
        send_random(4, 1'b1);
        tick(3);
        verify_writes("t5");

        // 6: one-cycle pulse counts, sub-cycle glitch does not; 3-cycle capture latency
        do_reset();
        clear_logs();
        b = 8'($urandom_range(0, 255));
        port_in = b;
        tick(1);
        port_strobe = 1'b1;
        tick(1);
        port_strobe = 1'b0;
        tick(4);
        exp_bytes.push_back(b);
        port_in = 8'($urandom_range(0, 255));
        tick(1);
        #1 port_strobe = 1'b1;
        #2 port_strobe = 1'b0;
        tick(4);
        send_random(2, 1'b1);
        b = 8'($urandom_range(0, 255));
        port_in = b;
        tick(1);
        port_strobe = 1'b1;
        tick(2);
        check("t6.before_capture", 64'(bus.mem_we), 64'd0);
        tick(1);
        check("t6.at_capture", 64'(bus.mem_we), 64'd1);
        exp_bytes.push_back(b);
        port_strobe = 1'b0;
        tick(4);
        verify_writes("t6");
        check("t6.overflow", 64'(overflow), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
